uart_tx_queue: RTL
==================

// Module: uart_tx_queue
// PURPOSE
//  Byte FIFO and handshake sequencer directly upstream of the UART transmitter.
//  Producers push bytes at any rate. The block stores up to 2**DEPTH_LOG2 bytes
//  and feeds them one at a time into the UART TX port using the UART protocol:
//  data stable -> wait busy low -> send high -> wait busy high -> send low.
//  Removes per-byte handshake logic from counter/display producers.
// PARAMETERS
//  DEPTH_LOG2    4      FIFO depth = 2**DEPTH_LOG2 entries (16)
//  DATA_WIDTH    8      byte width; must match UART ipTxData
//  SEND_TIMEOUT  1024   max cycles in SEND waiting for ipTxBusy rise before abort
// PORTS
//  ipClk          in   1             system clock (50 MHz)
//  ipReset        in   1             asynchronous, active-high reset
//  ipWrData       in   DATA_WIDTH    byte to enqueue
//  ipWrValid      in   1             enqueue request
//  opWrReady      out  1             FIFO not full; push accepted when ipWrValid&&opWrReady
//  opTxData       out  DATA_WIDTH    to UART ipTxData
//  opTxSend       out  1             to UART ipTxSend
//  ipTxBusy       in   1             from UART opTxBusy
//  opCount        out  DEPTH_LOG2+1  bytes held in FIFO (excludes byte in flight)
//  opEmpty        out  1             opCount==0
//  opOverflow     out  1             sticky: push attempted while full
//  opTimeout      out  1             sticky: SEND aborted by watchdog
//  ipClrFlags     in   1             sync clear of opOverflow and opTimeout
// BEHAVIOUR
//  Reset (async assert, sync-released): opTxSend=0, opTxData=0, opCount=0,
//   opEmpty=1, opWrReady=1, opOverflow=0, opTimeout=0, state=IDLE, pointers=0;
//   FIFO contents are discarded. Reset mid-handshake drops opTxSend immediately.
//  FIFO: rd/wr pointers DEPTH_LOG2 bits, wrap modulo depth; count DEPTH_LOG2+1 bits.
//   opWrReady = !(opCount==2**DEPTH_LOG2), combinational from registered count.
//   Push and pop in the same cycle: count unchanged, both pointers advance.
//   Push while full: data dropped, no pointer move, opOverflow<=1.
//   ipClrFlags and a new set event in the same cycle: set wins.
//  FSM (registered outputs):
//   IDLE      : if !opEmpty -> opTxData<=mem[rd], rd++, count-- (pop) -> WAIT_FREE
//   WAIT_FREE : if !ipTxBusy -> opTxSend<=1, clear watchdog -> SEND
//   SEND      : if ipTxBusy -> opTxSend<=0 -> IDLE
//               else if watchdog==SEND_TIMEOUT-1 -> opTxSend<=0, opTimeout<=1 -> IDLE
//               (byte lost); watchdog increments each SEND cycle
//  opTxData holds its value from the pop until the next pop.
//  Latency: byte pushed at edge k into empty FIFO with UART idle ->
//   opTxData valid after edge k+1, opTxSend=1 after edge k+2.
//  Back-to-back: the next pop occurs in IDLE while UART is still busy. WAIT_FREE
//   holds opTxSend low until ipTxBusy falls, so the protocol is never violated.
//  opTxSend is never high while in IDLE or WAIT_FREE.
// STRUCTURE
//  Shared header uart_defs.vh: UART_DATA_WIDTH=8, FSM state encodings
//   (IDLE=2'd0, WAIT_FREE=2'd1, SEND=2'd2). The UART RX-side blocks reuse it.
//  One sub-module: sync_fifo (storage, pointers, count, full/empty, overflow).
//   uart_tx_queue contains the handshake FSM and watchdog only.
// TESTING
//  Bench includes a behavioural UART model: busy rises 2 cycles after send, held 100 cycles.
//  1. Reset, push 0xA5 -> opTxData=0xA5 after k+1, opTxSend=1 after k+2; falls after busy rises.
//  2. Push 0x01..0x10 back-to-back -> 16 accepted; opWrReady=0 at count 16 (pop not yet
//     taken) or count 15 tracks; UART sees bytes 0x01..0x10 in order, none lost.
//  3. Fill to 16 with UART busy held, push 0xFF -> dropped, opOverflow=1;
//     ipClrFlags -> opOverflow=0.
//  4. Model never raises busy -> after 1024 SEND cycles opTxSend=0, opTimeout=1,
//     next byte proceeds.
//  5. Assert ipReset while opTxSend=1 with 5 bytes queued -> opTxSend=0 the same cycle,
//     opCount=0, opEmpty=1.
//  6. Push and pop in the same cycle at count 8 -> count stays 8; pointer wrap past
//     entry 15 preserves order.

Source files
------------

// File: rtl/uart_tx_queue_pkg.sv
// Shared UART definitions: byte width and TX handshake state encodings.
// The RX-side blocks import the same package.
package uart_tx_queue_pkg;

    localparam int UART_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FREE = 2'd1,
        SEND      = 2'd2
    } txState_t;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous byte FIFO with occupancy count, full/empty status and a sticky
// overflow flag for pushes attempted while full.
module sync_fifo
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    input  logic [DATA_WIDTH-1:0] ipWrData,
    input  logic                  ipWrValid,
    output logic                  opWrReady,
    input  logic                  ipRdEn,
    output logic [DATA_WIDTH-1:0] opRdData,
    output logic [DEPTH_LOG2:0]   opCount,
    output logic                  opEmpty,
    output logic                  opOverflow,
    input  logic                  ipClrFlags
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic                  full;
    logic                  doPush;
    logic                  doPop;

    assign full      = (opCount == (DEPTH_LOG2 + 1)'(DEPTH));
    assign opWrReady = !full;
    assign opEmpty   = (opCount == '0);
    assign doPush    = ipWrValid && !full;
    assign doPop     = ipRdEn && !opEmpty;
    assign opRdData  = mem[rdPtr];

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            opCount    <= '0;
            opOverflow <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   opCount <= opCount + 1'b1;
                2'b01:   opCount <= opCount - 1'b1;
                default: opCount <= opCount;
            endcase
            // A new overflow in the same cycle as a clear must stay visible.
            if (ipWrValid && full) opOverflow <= 1'b1;
            else if (ipClrFlags)   opOverflow <= 1'b0;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge ipClk) begin
        if (doPush) mem[wrPtr] <= ipWrData;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the UART transmitter: buffers producer bytes and runs
// the send/busy handshake per byte, with a watchdog on the busy acknowledge.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2   = 4,
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int SEND_TIMEOUT = 1024
) (
    input  logic                  ipClk,
    input  logic                  ipReset,
    input  logic [DATA_WIDTH-1:0] ipWrData,
    input  logic                  ipWrValid,
    output logic                  opWrReady,
    output logic [DATA_WIDTH-1:0] opTxData,
    output logic                  opTxSend,
    input  logic                  ipTxBusy,
    output logic [DEPTH_LOG2:0]   opCount,
    output logic                  opEmpty,
    output logic                  opOverflow,
    output logic                  opTimeout,
    input  logic                  ipClrFlags
);

    localparam int WD_W = $clog2(SEND_TIMEOUT + 1);

    txState_t              state;
    txState_t              stateNext;
    logic [WD_W-1:0]       watchdog;
    logic [WD_W-1:0]       watchdogNext;
    logic                  wdExpired;
    logic                  fifoPop;
    logic [DATA_WIDTH-1:0] fifoData;
    logic [DATA_WIDTH-1:0] txDataNext;
    logic                  sendNext;
    logic                  timeoutSet;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) uFifo (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .ipWrData   (ipWrData),
        .ipWrValid  (ipWrValid),
        .opWrReady  (opWrReady),
        .ipRdEn     (fifoPop),
        .opRdData   (fifoData),
        .opCount    (opCount),
        .opEmpty    (opEmpty),
        .opOverflow (opOverflow),
        .ipClrFlags (ipClrFlags)
    );

    assign wdExpired = (watchdog == WD_W'(SEND_TIMEOUT - 1));

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state     <= IDLE;
            opTxSend  <= 1'b0;
            opTxData  <= '0;
            watchdog  <= '0;
            opTimeout <= 1'b0;
        end else begin
            state    <= stateNext;
            opTxSend <= sendNext;
            opTxData <= txDataNext;
            watchdog <= watchdogNext;
            if (timeoutSet)      opTimeout <= 1'b1;
            else if (ipClrFlags) opTimeout <= 1'b0;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (!opEmpty) stateNext = WAIT_FREE;
            WAIT_FREE: if (!ipTxBusy) stateNext = SEND;
            SEND:      if (ipTxBusy || wdExpired) stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // Send is raised only from WAIT_FREE and held through SEND until busy
    // rises or the watchdog gives up; the byte is dropped on abort.
    always_comb begin
        fifoPop      = (state == IDLE) && !opEmpty;
        txDataNext   = fifoPop ? fifoData : opTxData;
        sendNext     = 1'b0;
        watchdogNext = '0;
        timeoutSet   = 1'b0;
        case (state)
            WAIT_FREE: sendNext = !ipTxBusy;
            SEND: begin
                sendNext     = !ipTxBusy && !wdExpired;
                watchdogNext = watchdog + 1'b1;
                timeoutSet   = !ipTxBusy && wdExpired;
            end
            default: ;
        endcase
    end

endmodule
